// File: rtl/nn_mul_arbiter_if.sv
// rtl/nn_mul_arbiter_if.sv - requester-side operand/result bus of the shared FP multiplier arbiter
interface nn_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data
  );

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/nn_mul_arbiter.sv
// rtl/nn_mul_arbiter.sv - round-robin share of one fixed-latency FP multiplier among NUM_REQ requesters
// Optional per-requester grant counters under NN_ARB_STATS_EN.
module nn_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 3,
  parameter int DATA_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst_l,
  nn_mul_arbiter_if.slave            req,
  output logic                       mul_in_valid,
  output logic [DATA_W-1:0]          mul_a,
  output logic [DATA_W-1:0]          mul_b,
  input  logic                       mul_out_valid,
  input  logic [DATA_W-1:0]          mul_result,
  output logic                       busy,
  output logic                       err
`ifdef NN_ARB_STATS_EN
  ,
  input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
  output logic [15:0]                stat_count
`endif
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0]                  rr_ptr;
  logic [IDW-1:0]                  grant_id;
  logic                            grant_found;
  logic [IDW-1:0]                  issue_id;
  logic [MUL_LATENCY-1:0]          tag_v;
  logic [MUL_LATENCY-1:0][IDW-1:0] tag_id;
  logic                            last_v;
  logic [IDW-1:0]                  last_id;
  logic                            ret_ok;
  int                              idx;

  // Search starts just past the last winner, so a holder of valid cannot starve others.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && req.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    req.req_ready = '0;
    if (grant_found) begin
      req.req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rr_ptr       <= IDW'(NUM_REQ - 1);
      mul_in_valid <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      issue_id     <= '0;
    end else begin
      mul_in_valid <= grant_found;
      if (grant_found) begin
        rr_ptr   <= grant_id;
        issue_id <= grant_id;
        mul_a    <= req.req_a[int'(grant_id)*DATA_W +: DATA_W];
        mul_b    <= req.req_b[int'(grant_id)*DATA_W +: DATA_W];
      end
    end
  end

  // Stage MUL_LATENCY-1 is valid in exactly the cycle the multiplier should strobe.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= mul_in_valid;
      tag_id[0] <= issue_id;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign last_v  = tag_v[MUL_LATENCY-1];
  assign last_id = tag_id[MUL_LATENCY-1];
  assign ret_ok  = mul_out_valid && last_v;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      req.rsp_valid <= '0;
      req.rsp_data  <= '0;
      err           <= 1'b0;
    end else begin
      req.rsp_valid <= '0;
      if (ret_ok) begin
        req.rsp_valid[last_id] <= 1'b1;
        req.rsp_data           <= mul_result;
      end
      if (mul_out_valid != last_v) begin
        err <= 1'b1;
      end
    end
  end

  assign busy = mul_in_valid | (|tag_v) | (|req.rsp_valid);

`ifdef NN_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      grant_cnt <= '0;
    end else if (grant_found && grant_cnt[grant_id] != 16'hFFFF) begin
      grant_cnt[grant_id] <= grant_cnt[grant_id] + 16'd1;
    end
  end

  assign stat_count = (int'(stat_sel) < NUM_REQ) ? grant_cnt[stat_sel] : 16'd0;
`endif

endmodule
